// File: rtl/d_ff_change_monitor_if.sv
// Event drain port of the d_ff change monitor: show-ahead head entry plus
// valid/ready handshake.
interface d_ff_change_monitor_if #(
    parameter int WIDTH = 3
);
    logic             ev_valid;
    logic             ev_ready;
    logic [WIDTH-1:0] ev_prev;
    logic [WIDTH-1:0] ev_curr;

    modport master (output ev_valid, ev_prev, ev_curr, input ev_ready);
    modport slave  (input ev_valid, ev_prev, ev_curr, output ev_ready);
endinterface

// File: rtl/d_ff_change_monitor.sv
// Watches a registered d_ff bus, logs each value change as (prev, curr) in a
// show-ahead FIFO, and keeps a saturating change count and sticky overflow.
module d_ff_change_monitor #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         d_in,
    input  logic                     clr_ovf,
    d_ff_change_monitor_if.master    ev,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         chg_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    localparam logic [0:0] ARM = 1'b0;
    localparam logic [0:0] MON = 1'b1;

    logic [0:0]                     state;
    logic [WIDTH-1:0]               last;
    logic [DEPTH-1:0][2*WIDTH-1:0]  mem;
    logic [AW-1:0]                  wr_ptr;
    logic [AW-1:0]                  rd_ptr;
    logic                           chg;
    logic                           full;
    logic                           pop;
    logic                           push;
    logic                           drop;

    assign chg  = (state == MON) && (d_in != last);
    assign full = (level == FULL_LVL);
    assign pop  = ev.ev_valid && ev.ev_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push = chg && (!full || pop);
    assign drop = chg && full && !pop;

    assign ev.ev_valid = (level != '0);
    // Gated so stale RAM contents never show while empty or in reset.
    assign ev.ev_prev  = ev.ev_valid ? mem[rd_ptr][2*WIDTH-1:WIDTH] : '0;
    assign ev.ev_curr  = ev.ev_valid ? mem[rd_ptr][WIDTH-1:0]       : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARM;
            last     <= '0;
            chg_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    last  <= d_in;
                    state <= MON;
                end
                default: begin
                    if (chg) begin
                        last <= d_in;
                        if (chg_cnt != '1)
                            chg_cnt <= chg_cnt + CNT_W'(1);
                    end
                end
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {last, d_in};
    end
endmodule
